// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ALU-operand forwarding selects and load-use stall request for the 5-stage core.
// Latency: forward_a/forward_b/stall are combinational; shadow ID/EX, EX/MEM, MEM/WB advance every clk.
// Backpressure: none accepted; raises stall for exactly one cycle per load-use pair, flush overrides it.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_valid          ID stage holds a real instruction
//   id_rs1, id_rs2    ID source registers; id_rs2_used qualifies id_rs2
//   id_rd             ID destination; id_reg_write / id_mem_read describe it
//   flush             branch taken in EX, squash the ID instruction
//   forward_a/b       operand selects: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result
//   stall             hold PC and IF/ID, bubble into ID/EX
//   stall_count       cumulative stall cycles
//
// Build option: define FWD_STALL_COUNTER_EN to build the stall-cycle counter;
// without it stall_count is tied to 0 but the port is kept.

module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  // Shadow of the ID/EX pipeline register: only what forwarding and
  // load-use detection need.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } idex_t;

  // Shadow of EX/MEM and MEM/WB: the writer identity is all we track.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wr_ctl_t;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  idex_t   idex_q;
  idex_t   idex_d;
  wr_ctl_t exmem_q;
  wr_ctl_t memwb_q;

  logic rs1_hit;
  logic rs2_hit;
  logic bubble;
  logic exmem_fwd_ok;
  logic memwb_fwd_ok;

  // ------------------------------------------------------------------
  // Load-use detection. The load in EX cannot supply its data until
  // MEM/WB, so a dependent instruction in ID must wait one cycle. A
  // flushed or invalid ID slot never stalls.
  // ------------------------------------------------------------------
  always_comb begin
    rs1_hit = (idex_q.rd == id_rs1);
    rs2_hit = id_rs2_used && (idex_q.rd == id_rs2);
    stall   = id_valid && !flush && idex_q.mem_read &&
              (idex_q.rd != '0) && (rs1_hit || rs2_hit);
  end

  assign bubble = stall || flush || !id_valid;

  // ID/EX next state. Unused rs2 is zeroed so a stale rs2 field can
  // never produce a false forward (x0 is never forwarded).
  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.rs1       = id_rs1;
      idex_d.rs2       = id_rs2_used ? id_rs2 : '0;
      idex_d.rd        = id_rd;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
    end
  end

  // EX/MEM and MEM/WB always advance; the stall only holds the front
  // end, and the bubble it injects is what drains the load-use pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q            <= idex_d;
      exmem_q.rd        <= idex_q.rd;
      exmem_q.reg_write <= idex_q.reg_write;
      memwb_q           <= exmem_q;
    end
  end

  // ------------------------------------------------------------------
  // Forwarding selects. EX/MEM is checked first so the youngest
  // producer wins when both stages write the same register.
  // ------------------------------------------------------------------
  always_comb begin
    exmem_fwd_ok = exmem_q.reg_write && (exmem_q.rd != '0);
    memwb_fwd_ok = memwb_q.reg_write && (memwb_q.rd != '0);

    forward_a = SEL_RF;
    if (exmem_fwd_ok && (exmem_q.rd == idex_q.rs1)) begin
      forward_a = SEL_EXMEM;
    end else if (memwb_fwd_ok && (memwb_q.rd == idex_q.rs1)) begin
      forward_a = SEL_MEMWB;
    end

    forward_b = SEL_RF;
    if (exmem_fwd_ok && (exmem_q.rd == idex_q.rs2)) begin
      forward_b = SEL_EXMEM;
    end else if (memwb_fwd_ok && (memwb_q.rd == idex_q.rs2)) begin
      forward_b = SEL_MEMWB;
    end
  end

  // ------------------------------------------------------------------
  // Stall-cycle counter, wraps naturally at 2^CNT_W.
  // ------------------------------------------------------------------
`ifdef FWD_STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed instruction-sequence table plus random stimulus
// checked against an in-flight instruction model of the EX/MEM/WB stages.

module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic [1:0]    forward_a;
  logic [1:0]    forward_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // One ID-stage slot per cycle plus the outputs expected in that cycle.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          used;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          fl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          st;
  } vec_t;

  // An instruction in flight past ID.
  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
  } minst_t;

  vec_t          tbl[$];
  minst_t        pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  int            vectors     = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_cnt     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic row(input int v, input int rs1, input int rs2, input int used,
                     input int rd, input int rw, input int mr, input int fl,
                     input int fa, input int fb, input int st);
    vec_t t;
    t.v    = (v != 0);
    t.rs1  = AW'(rs1);
    t.rs2  = AW'(rs2);
    t.used = (used != 0);
    t.rd   = AW'(rd);
    t.rw   = (rw != 0);
    t.mr   = (mr != 0);
    t.fl   = (fl != 0);
    t.fa   = 2'(fa);
    t.fb   = 2'(fb);
    t.st   = (st != 0);
    tbl.push_back(t);
  endtask

  task automatic nop(input int fa, input int fb);
    row(0, 0, 0, 0, 0, 0, 0, 0, fa, fb, 0);
  endtask

  task automatic drive(input vec_t t);
    id_valid     = t.v;
    id_rs1       = t.rs1;
    id_rs2       = t.rs2;
    id_rs2_used  = t.used;
    id_rd        = t.rd;
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
    flush        = t.fl;
  endtask

  // Newest older writer of src supplies it: MEM (one ahead) gives 10, WB gives 01.
  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    for (int k = 1; k < 3; k++) begin
      if (pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  // A load sitting in EX whose result the live ID instruction reads.
  function automatic logic m_stall();
    return id_valid && !flush && pipe[0].mr && pipe[0].rd != 0 &&
           (pipe[0].rd == id_rs1 || (id_rs2_used && pipe[0].rd == id_rs2));
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
  endtask

  task automatic m_clock(input logic st);
    minst_t n;
    n = '0;
    if (id_valid && !flush && !st) begin
      n.rs1 = id_rs1;
      n.rs2 = id_rs2_used ? id_rs2 : '0;
      n.rd  = id_rd;
      n.rw  = id_reg_write;
      n.mr  = id_mem_read;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
`ifdef FWD_STALL_COUNTER_EN
    if (st) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  task automatic step(input vec_t t, input logic use_tbl);
    logic st_m;
    @(negedge clk);
    drive(t);
    #1;
    st_m = m_stall();
    if (use_tbl) begin
      check("tbl_forward_a", 32'(forward_a), 32'(t.fa));
      check("tbl_forward_b", 32'(forward_b), 32'(t.fb));
      check("tbl_stall",     32'(stall),     32'(t.st));
    end else begin
      check("rnd_forward_a", 32'(forward_a), 32'(m_fwd(pipe[0].rs1)));
      check("rnd_forward_b", 32'(forward_b), 32'(m_fwd(pipe[0].rs2)));
      check("rnd_stall",     32'(stall),     32'(st_m));
    end
    check("stall_count", stall_count, exp_cnt);
    @(posedge clk);
    m_clock(st_m);
  endtask

  initial begin
    vec_t t;
    reset = 1'b1;
    t = '0;
    drive(t);
    m_clear();

    // EX/MEM forward: add x5,x1,x2 ; sub x6,x5,x3
    row(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    row(1, 5, 3, 1, 6, 1, 0, 0, 0, 0, 0);
    nop(2, 0); nop(0, 0); nop(0, 0);
    // MEM/WB forward: add x5 ; add x8,x1,x2 ; or x7,x4,x5
    row(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    row(1, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0);
    row(1, 4, 5, 1, 7, 1, 0, 0, 0, 0, 0);
    nop(0, 1); nop(0, 0); nop(0, 0);
    // Double hazard: add x5 ; addi x5,x5,1 ; and x8,x5,x5
    row(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    row(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    row(1, 5, 5, 1, 8, 1, 0, 0, 2, 0, 0);
    nop(2, 2); nop(0, 0); nop(0, 0);
    // Load-use on rs1: ld x9,0(x2) ; add x10,x9,x1 (held one cycle)
    row(1, 2, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    row(1, 9, 1, 1, 10, 1, 0, 0, 0, 0, 1);
    row(1, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0);
    nop(1, 0); nop(0, 0); nop(0, 0);
    // x0 destination: addi x0 ; add x3,x0,x0
    row(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);
    // Unused rs2: ld x4 ; addi x5,x6,4 with rs2 field 4
    row(1, 2, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    row(1, 6, 4, 0, 5, 1, 0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);
    // Flush in the hazard cycle
    row(1, 2, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    row(1, 9, 1, 1, 10, 1, 0, 1, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);
    // Invalid ID slot never stalls nor enters EX
    row(1, 2, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    row(0, 9, 9, 1, 10, 1, 0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);
    // Load-use on rs2: ld x7 ; add x1,x2,x7
    row(1, 3, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    row(1, 2, 7, 1, 1, 1, 0, 0, 0, 0, 1);
    row(1, 2, 7, 1, 1, 1, 0, 0, 0, 0, 0);
    nop(0, 1); nop(0, 0); nop(0, 0);
    // Load to x0 is not a hazard
    row(1, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    row(1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 0); nop(0, 0);

    #12;
    check("reset_forward_a", 32'(forward_a), 32'd0);
    check("reset_forward_b", 32'(forward_b), 32'd0);
    check("reset_stall",     32'(stall),     32'd0);
    check("reset_count",     stall_count,    32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Mid-stream reset: add x5 ; ld x9,0(x5) ; add x10,x9,x1 then reset
    t = '0; t.v = 1; t.rs1 = 1; t.rs2 = 2; t.used = 1; t.rd = 5; t.rw = 1;
    step(t, 1'b1);
    t = '0; t.v = 1; t.rs1 = 5; t.rd = 9; t.rw = 1; t.mr = 1;
    step(t, 1'b1);
    @(negedge clk);
    t = '0; t.v = 1; t.rs1 = 9; t.rs2 = 1; t.used = 1; t.rd = 10; t.rw = 1;
    drive(t);
    #1;
    check("pre_reset_forward_a", 32'(forward_a), 32'd2);
    check("pre_reset_stall",     32'(stall),     32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_forward_a", 32'(forward_a), 32'd0);
    check("async_reset_forward_b", 32'(forward_b), 32'd0);
    check("async_reset_stall",     32'(stall),     32'd0);
    check("async_reset_count",     stall_count,    32'd0);
    m_clear();
    exp_cnt = '0;
    t = '0;
    drive(t);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // First instruction after reset sees an empty pipeline.
    t = '0; t.v = 1; t.rs1 = 9; t.rs2 = 5; t.used = 1; t.rd = 3; t.rw = 1;
    step(t, 1'b1);

    // Random phase against the in-flight model.
    for (int n = 0; n < 1500; n++) begin
      t      = '0;
      t.v    = ($urandom_range(0, 99) < 85);
      t.rs1  = AW'($urandom_range(0, 7));
      t.rs2  = AW'($urandom_range(0, 7));
      t.used = ($urandom_range(0, 99) < 60);
      t.rd   = AW'($urandom_range(0, 7));
      t.rw   = ($urandom_range(0, 99) < 80);
      t.mr   = t.rw && ($urandom_range(0, 99) < 35);
      t.fl   = ($urandom_range(0, 99) < 8);
      step(t, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
